// File: rtl/i2s_ws_gen_if.sv
// ---------------------------------------------------------------------------
// i2s_ws_gen_if
// Configuration and framing bundle between a controller and the I2S
// word-select generator.
//   cfg_en_i        run (1) / stop at end of current frame (0)
//   cfg_update_i    request capture of cfg_* into the shadow registers
//   cfg_wlen_i[4:0] bits per word minus 1
//   cfg_wnum_i[2:0] words per half-frame minus 1
//   cfg_ws_delay_i  0 = left-justified WS, 1 = I2S WS (one bit early)
//   ws_o            word select, 0 = left half, 1 = right half
//   word_start_o    first bit of every word
//   frame_start_o   first bit of every frame
//   ch_en_o         RX channel enable
//   busy_o          generator not idle
//   cfg_wlen_o[4:0] frame-aligned word length for the RX channel
//   cfg_wnum_o[2:0] frame-aligned word count for the RX channel
// Modports: master = controller side, slave = generator side.
// ---------------------------------------------------------------------------
interface i2s_ws_gen_if;
    logic       cfg_en_i;
    logic       cfg_update_i;
    logic [4:0] cfg_wlen_i;
    logic [2:0] cfg_wnum_i;
    logic       cfg_ws_delay_i;
    logic       ws_o;
    logic       word_start_o;
    logic       frame_start_o;
    logic       ch_en_o;
    logic       busy_o;
    logic [4:0] cfg_wlen_o;
    logic [2:0] cfg_wnum_o;

    modport master (
        output cfg_en_i, cfg_update_i, cfg_wlen_i, cfg_wnum_i, cfg_ws_delay_i,
        input  ws_o, word_start_o, frame_start_o, ch_en_o, busy_o,
               cfg_wlen_o, cfg_wnum_o
    );

    modport slave (
        input  cfg_en_i, cfg_update_i, cfg_wlen_i, cfg_wnum_i, cfg_ws_delay_i,
        output ws_o, word_start_o, frame_start_o, ch_en_o, busy_o,
               cfg_wlen_o, cfg_wnum_o
    );
endinterface

// File: rtl/i2s_ws_gen.sv
// ---------------------------------------------------------------------------
// i2s_ws_gen
// Word-select generator and frame sequencer for the I2S receive path.
// Counts bits per word and words per half-frame, drives WS and the word /
// frame strobes, gates the RX channel at frame boundaries and presents a
// frame-aligned shadow of the word-length / word-count configuration.
// All state changes on the falling edge of sck_i so consumers can sample
// on the rising edge.
// Ports:
//   sck_i   serial bit clock
//   rstn_i  asynchronous active-low reset
//   bus     i2s_ws_gen_if.slave (configuration in, framing outputs out)
// ---------------------------------------------------------------------------
module i2s_ws_gen (
    input  logic          sck_i,
    input  logic          rstn_i,
    i2s_ws_gen_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] bit_q, bit_d;
    logic [2:0] word_q, word_d;
    logic       half_q, half_d;
    logic [4:0] wlen_s_q, wlen_s_d;
    logic [2:0] wnum_s_q, wnum_s_d;
    logic       delay_s_q, delay_s_d;

    // Registered outputs, derived from the current state each edge.
    logic       ws_q, word_start_q, frame_start_q, ch_en_q, busy_q;
    logic [4:0] cfg_wlen_q;
    logic [2:0] cfg_wnum_q;

    logic word_end, half_end, frame_end, run;

    assign word_end  = (bit_q == wlen_s_q);
    assign half_end  = word_end && (word_q == wnum_s_q);
    assign frame_end = half_end && half_q;
    assign run       = (state_q == RUN);

    // NOTE: every signal driven here gets its default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        word_d    = word_q;
        half_d    = half_q;
        wlen_s_d  = wlen_s_q;
        wnum_s_d  = wnum_s_q;
        delay_s_d = delay_s_q;

        case (state_q)
            IDLE: begin
                bit_d  = '0;
                word_d = '0;
                half_d = 1'b0;
                if (bus.cfg_update_i) begin
                    wlen_s_d  = bus.cfg_wlen_i;
                    wnum_s_d  = bus.cfg_wnum_i;
                    delay_s_d = bus.cfg_ws_delay_i;
                end
                if (bus.cfg_en_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (word_end) begin
                    bit_d = '0;
                    if (half_end) begin
                        word_d = '0;
                        half_d = ~half_q;
                    end else begin
                        word_d = word_q + 3'd1;
                    end
                end else begin
                    bit_d = bit_q + 5'd1;
                end
                // Shadow and run/stop decisions only at a frame boundary,
                // so a frame is never split across two configurations.
                if (frame_end) begin
                    if (bus.cfg_update_i) begin
                        wlen_s_d  = bus.cfg_wlen_i;
                        wnum_s_d  = bus.cfg_wnum_i;
                        delay_s_d = bus.cfg_ws_delay_i;
                    end
                    if (!bus.cfg_en_i) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                state_d = IDLE;
                bit_d   = '0;
                word_d  = '0;
                half_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                bit_d   = '0;
                word_d  = '0;
                half_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(negedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            bit_q     <= '0;
            word_q    <= '0;
            half_q    <= 1'b0;
            wlen_s_q  <= '0;
            wnum_s_q  <= '0;
            delay_s_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            word_q    <= word_d;
            half_q    <= half_d;
            wlen_s_q  <= wlen_s_d;
            wnum_s_q  <= wnum_s_d;
            delay_s_q <= delay_s_d;
        end
    end

    // Output stage: one register behind the sequencer state, so outputs
    // describe the bit the counters held before this edge. In I2S mode WS
    // shows the half the next bit belongs to, i.e. it flips on the last
    // bit of each half.
    always_ff @(negedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ws_q          <= 1'b0;
            word_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            ch_en_q       <= 1'b0;
            busy_q        <= 1'b0;
            cfg_wlen_q    <= '0;
            cfg_wnum_q    <= '0;
        end else begin
            ws_q          <= run && (delay_s_q ? (half_q ^ half_end) : half_q);
            word_start_q  <= run && (bit_q == 5'd0);
            frame_start_q <= run && (bit_q == 5'd0) && (word_q == 3'd0) && !half_q;
            ch_en_q       <= run;
            busy_q        <= (state_q != IDLE);
            cfg_wlen_q    <= wlen_s_q;
            cfg_wnum_q    <= wnum_s_q;
        end
    end

    assign bus.ws_o          = ws_q;
    assign bus.word_start_o  = word_start_q;
    assign bus.frame_start_o = frame_start_q;
    assign bus.ch_en_o       = ch_en_q;
    assign bus.busy_o        = busy_q;
    assign bus.cfg_wlen_o    = cfg_wlen_q;
    assign bus.cfg_wnum_o    = cfg_wnum_q;

endmodule

// File: doc/i2s_ws_gen.md
# i2s_ws_gen

Word-select generator and frame sequencer for the I2S receive path. It runs on the serial bit clock and does four things:
- counts bits per word and words per channel half-frame;
- drives the WS line and the word- and frame-boundary strobes;
- gates the RX channel on and off at frame boundaries;
- presents a shadowed, frame-aligned copy of the word-length and word-count configuration to the RX channels.

This guarantees that configuration changes never split a frame.

## Interface
Parameters: none.

Ports:
- sck_i  in  1  serial bit clock; all state updates on the falling edge, so consumers sample outputs on the rising edge
- rstn_i  in  1  asynchronous active-low reset
- cfg_en_i  in  1  level; 1 = run, 0 = stop at the end of the current frame
- cfg_update_i  in  1  level; 1 = capture cfg_* into shadow at the next allowed point
- cfg_wlen_i  in  5  bits per word minus 1 (0..31 gives 1..32 bits)
- cfg_wnum_i  in  3  words per half-frame minus 1 (0..7 gives 1..8 words)
- cfg_ws_delay_i  in  1  0 = left-justified WS; 1 = I2S WS, leading by one bit
- ws_o  out  1  word select; 0 = left half, 1 = right half
- word_start_o  out  1  high during the first bit of every word
- frame_start_o  out  1  high during the first bit of every frame
- ch_en_o  out  1  RX channel enable; high while frames are being sequenced
- busy_o  out  1  state is not IDLE
- cfg_wlen_o  out  5  active (shadow) word length, feeds the RX channel
- cfg_wnum_o  out  3  active (shadow) word count, feeds the RX channel

## Operation
Internal state:
- r_bit (5 bits), r_word (3 bits), r_half (1 bit).
- Shadow registers: wlen_s, wnum_s, delay_s.

States:
- IDLE
  - Counters are held at 0 and all strobes are 0.
  - If cfg_update_i=1, shadow registers load cfg_* on every falling edge.
  - If cfg_en_i=1, go to RUN with r_bit=r_word=r_half=0. Shadow load and the transition to RUN happen on the same edge, so the new config applies to the first frame.
- RUN
  - Each edge increments r_bit.
  - Word end: r_bit==wlen_s. r_bit returns to 0 and r_word increments.
  - Half end: word end with r_word==wnum_s. r_word returns to 0 and r_half toggles.
  - Frame end: half end with r_half=1.
  - At frame end:
    - if cfg_update_i=1, the shadow registers load;
    - if cfg_en_i=0, go to STOP; otherwise start the next frame.
- STOP
  - Lasts exactly one bit period, the bit after the last frame.
  - ch_en_o=0, ws_o=0 and counters are 0.
  - Next state is IDLE.
  - If cfg_en_i has returned to 1 during STOP, go straight from IDLE to RUN on the following edge.

Output rules:
- cfg_update_i in RUN is ignored except at frame end. Shadow outputs never change in the middle of a frame.
- word_start_o = RUN and r_bit==0.
- frame_start_o = word_start_o and r_word==0 and r_half==0.
- ch_en_o = RUN.
- busy_o = RUN or STOP.
- ws_o when delay_s=0: equals r_half in RUN, and 0 otherwise.
- ws_o when delay_s=1: equals the value r_half will hold on the next bit, so WS changes one bit before the MSB.
  - On the final bit of a frame ws_o=0.
  - On the final bit of the left half ws_o=1.
  - In IDLE and STOP ws_o=0.
- All outputs are registered; none has a combinational path from cfg_* inputs.

Edge cases:
- Configuration changes while running take effect exactly at the next frame boundary.
- With wlen=0, every bit is a word; word_start_o stays high for the whole RUN time.
- With wnum=0 and wlen=0, the frame is 2 bits and ws_o toggles every bit.
- Reset at any point forces IDLE:
  - counters and shadow registers = 0;
  - all outputs = 0, including cfg_wlen_o=0 and cfg_wnum_o=0.

## Timing
- Start latency: cfg_en_i sampled high at falling edge N in IDLE. RUN, frame_start_o=1 and word_start_o=1 are visible after edge N+1.
- Frame length: 2 × (wnum_s+1) × (wlen_s+1) bit periods.
- Stop latency: the disable takes effect after the current frame's last bit. There is one STOP bit, then IDLE.
- Shadow update: when the frame-end edge samples cfg_update_i=1, the new cfg_*_o values are valid during the first bit of the next frame. That first bit is also the bit where frame_start_o=1.
- Reset values: ws_o=0, word_start_o=0, frame_start_o=0, ch_en_o=0, busy_o=0, cfg_wlen_o=0, cfg_wnum_o=0.

## Test plan
1. Basic framing: wlen=15, wnum=0, delay=0, enable.
   - Expected: frame_start_o period 32; word_start_o period 16.
   - ws_o is 0 for bits 0-15 and 1 for bits 16-31.
2. I2S delay: same config with delay=1.
   - Expected: ws_o rises on bit 15 and falls on bit 31.
   - ws_o is 0 in IDLE before start and after stop.
3. Multi-word TDM: wlen=7, wnum=3.
   - Expected: 4 word_start_o pulses per half; frame length 64.
   - ws_o toggles every 32 bits.
4. Mid-frame reconfiguration: running with wlen=15; at bit 5, set cfg_update_i=1 and wlen=23.
   - Expected: cfg_wlen_o stays 15 through bit 31.
   - cfg_wlen_o becomes 23 on the next frame_start_o; the next frame has 48 bits.
5. Stop and restart: drop cfg_en_i at bit 10 of a 32-bit frame.
   - Expected: ch_en_o stays high until bit 31, then there is one STOP bit with busy_o=1, then IDLE.
   - When re-enabled during STOP, frame_start_o follows 2 bit periods after the last frame bit.
6. Async reset mid-frame (bit 20): all outputs go to 0 immediately, without waiting for a sck_i edge.
   - Expected: after release with cfg_en_i=1, frame_start_o appears after the second falling edge.
